// File: rtl/uart_core.sv
// rtl/uart_core.sv - UART block: 16x baud tick generator, 8N1 receiver and 8N1 transmitter
module uart_core #(
    parameter int DIV16 = 651
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    output logic       uart_txd,
    input  logic       rx_en,
    output logic [7:0] rx_data,
    output logic       rx_status,
    input  logic       tx_en,
    input  logic [7:0] txdata,
    input  logic       txstop,
    output logic       tx_status
);

    localparam int BW       = (DIV16 > 1) ? $clog2(DIV16) : 1;
    localparam int BIT_CLKS = 16 * DIV16;
    localparam int TW       = $clog2(BIT_CLKS);

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_WAIT  = 3'd4;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    logic [BW-1:0] baud_cnt;
    logic          tick16;
    logic          rxd_meta;
    logic          rxd_sync;
    logic [2:0]    rx_state;
    logic [3:0]    rx_tcnt;
    logic [2:0]    rx_bcnt;
    logic [7:0]    rx_shift;
    logic [1:0]    tx_state;
    logic [TW-1:0] tx_cnt;
    logic [2:0]    tx_bcnt;
    logic [7:0]    tx_shift;

    assign tick16 = (baud_cnt == BW'(DIV16 - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_cnt <= '0;
        end else if (tick16) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + BW'(1);
        end
    end

    // Synchroniser resets to the idle line level so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_sync <= rxd_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state  <= RX_IDLE;
            rx_tcnt   <= '0;
            rx_bcnt   <= '0;
            rx_shift  <= '0;
            rx_data   <= '0;
            rx_status <= 1'b0;
        end else begin
            rx_status <= 1'b0;
            if (!rx_en) begin
                rx_state <= RX_IDLE;
            end else if (tick16) begin
                case (rx_state)
                    RX_IDLE: begin
                        if (!rxd_sync) begin
                            rx_state <= RX_START;
                            rx_tcnt  <= '0;
                        end
                    end
                    RX_START: begin
                        // Eight ticks after the falling edge lands mid start bit.
                        if (rx_tcnt == 4'd7) begin
                            rx_tcnt <= '0;
                            rx_bcnt <= '0;
                            rx_state <= rxd_sync ? RX_IDLE : RX_DATA;
                        end else begin
                            rx_tcnt <= rx_tcnt + 4'd1;
                        end
                    end
                    RX_DATA: begin
                        rx_tcnt <= rx_tcnt + 4'd1;
                        if (rx_tcnt == 4'd15) begin
                            rx_shift <= {rxd_sync, rx_shift[7:1]};
                            rx_bcnt  <= rx_bcnt + 3'd1;
                            if (rx_bcnt == 3'd7) begin
                                rx_state <= RX_STOP;
                            end
                        end
                    end
                    RX_STOP: begin
                        rx_tcnt <= rx_tcnt + 4'd1;
                        if (rx_tcnt == 4'd15) begin
                            if (rxd_sync) begin
                                rx_data   <= rx_shift;
                                rx_status <= 1'b1;
                                rx_state  <= RX_IDLE;
                            end else begin
                                rx_state <= RX_WAIT;
                            end
                        end
                    end
                    RX_WAIT: begin
                        if (rxd_sync) begin
                            rx_state <= RX_IDLE;
                        end
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end
        end
    end

    assign tx_status = (tx_state == TX_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bcnt  <= '0;
            tx_shift <= '0;
            uart_txd <= 1'b1;
        end else if (tx_state == TX_IDLE) begin
            uart_txd <= 1'b1;
            if (tx_en && !txstop) begin
                tx_shift <= txdata;
                tx_state <= TX_START;
                tx_cnt   <= '0;
                uart_txd <= 1'b0;
            end
        end else if (tx_cnt == TW'(BIT_CLKS - 1)) begin
            tx_cnt <= '0;
            case (tx_state)
                TX_START: begin
                    tx_state <= TX_DATA;
                    tx_bcnt  <= '0;
                    uart_txd <= tx_shift[0];
                    tx_shift <= tx_shift >> 1;
                end
                TX_DATA: begin
                    tx_bcnt <= tx_bcnt + 3'd1;
                    if (tx_bcnt == 3'd7) begin
                        tx_state <= TX_STOP;
                        uart_txd <= 1'b1;
                    end else begin
                        uart_txd <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end else begin
            tx_cnt <= tx_cnt + TW'(1);
        end
    end

endmodule

// File: tb/tb_uart_core.sv
// tb/tb_uart_core.sv - directed bench for uart_core with an rx byte scoreboard
module tb_uart_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_drv = 1'b1;
    logic       loop = 1'b0;
    logic       rx_en = 1'b0;
    logic       tx_en = 1'b0;
    logic       txstop = 1'b0;
    logic [7:0] txdata = 8'h00;
    logic       rxd_in;
    logic       uart_txd;
    logic       rx_status;
    logic       tx_status;
    logic [7:0] rx_data;

    int         compared = 0;
    int         mismatched = 0;
    int         pulses = 0;
    int         exp_pulses = 0;
    int         lows;
    int         highs;
    logic [7:0] exp_q[$];

    assign rxd_in = loop ? uart_txd : rx_drv;

    uart_core #(.DIV16(4)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .uart_rxd  (rxd_in),
        .uart_txd  (uart_txd),
        .rx_en     (rx_en),
        .rx_data   (rx_data),
        .rx_status (rx_status),
        .tx_en     (tx_en),
        .txdata    (txdata),
        .txstop    (txstop),
        .tx_status (tx_status)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i == 9) return 1'b1;
        return b[i-1];
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic expect_byte);
        if (expect_byte) begin
            exp_q.push_back(b);
            exp_pulses++;
        end
        for (int i = 0; i < 10; i++) begin
            rx_drv = (i == 9) ? stop_bit : frame_bit(b, i);
            repeat (64) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    task automatic wait_status(input logic val);
        int n = 0;
        while (tx_status !== val && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("wait_tx_status", 32'(tx_status), 32'(val));
    endtask

    // Scoreboard side: every rx_status pulse must match the oldest expected byte.
    always @(negedge clk) begin
        if (rx_status === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0)
                check("rx_unexpected_pulse", 32'd1, 32'd0);
            else
                check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        // T1 reset values
        repeat (3) @(negedge clk);
        check("rst_txd", 32'(uart_txd), 32'd1);
        check("rst_tx_status", 32'(tx_status), 32'd1);
        check("rst_rx_status", 32'(rx_status), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // T2 transmit A5, txdata changed right after accept
        txdata = 8'hA5;
        tx_en  = 1'b1;
        @(negedge clk);
        tx_en  = 1'b0;
        txdata = 8'hFF;
        lows = 0;
        for (int n = 0; n < 640; n++) begin
            if (tx_status === 1'b0) lows++;
            if (n % 64 == 32)
                check($sformatf("tx_bit%0d", n / 64), 32'(uart_txd), 32'(frame_bit(8'hA5, n / 64)));
            @(negedge clk);
        end
        check("tx_busy_clks", 32'(lows), 32'd640);
        check("tx_status_after", 32'(tx_status), 32'd1);
        check("txd_after", 32'(uart_txd), 32'd1);

        // T3 receive 3C
        rx_en = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h3C, 1'b1, 1'b1);
        repeat (64) @(negedge clk);
        check("rx_pulses_3c", 32'(pulses), 32'(exp_pulses));
        check("rx_data_3c", 32'(rx_data), 32'h3C);

        // T4 glitch and framing error
        rx_drv = 1'b0;
        repeat (20) @(negedge clk);
        rx_drv = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_pulses", 32'(pulses), 32'(exp_pulses));
        send_frame(8'h55, 1'b0, 1'b0);
        repeat (100) @(negedge clk);
        check("frame_err_pulses", 32'(pulses), 32'(exp_pulses));
        check("frame_err_rx_data", 32'(rx_data), 32'h3C);

        // T5 txstop blocks accept; rx_en drop aborts reception
        txstop = 1'b1;
        tx_en  = 1'b1;
        txdata = 8'h00;
        highs = 0;
        repeat (200) begin
            if (uart_txd === 1'b1 && tx_status === 1'b1) highs++;
            @(negedge clk);
        end
        check("txstop_idle_clks", 32'(highs), 32'd200);
        tx_en  = 1'b0;
        txstop = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) rx_en = 1'b0;
            rx_drv = frame_bit(8'h81, i);
            repeat (64) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (64) @(negedge clk);
        rx_en = 1'b1;
        repeat (64) @(negedge clk);
        check("rx_abort_pulses", 32'(pulses), 32'(exp_pulses));
        check("rx_abort_rx_data", 32'(rx_data), 32'h3C);

        // T6 loopback, back-to-back frames with tx_en held
        loop = 1'b1;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h5A);
        exp_pulses += 3;
        txdata = 8'h00;
        tx_en  = 1'b1;
        wait_status(1'b0);
        txdata = 8'hFF;
        wait_status(1'b1);
        wait_status(1'b0);
        txdata = 8'h5A;
        wait_status(1'b1);
        wait_status(1'b0);
        tx_en = 1'b0;
        wait_status(1'b1);
        repeat (64) @(negedge clk);
        check("loop_pulses", 32'(pulses), 32'(exp_pulses));
        check("loop_queue_empty", 32'(exp_q.size()), 32'd0);
        check("loop_last_byte", 32'(rx_data), 32'h5A);
        loop = 1'b0;

        // Reset in the middle of a transmit frame
        txdata = 8'h00;
        tx_en  = 1'b1;
        @(negedge clk);
        tx_en = 1'b0;
        repeat (100) @(negedge clk);
        check("pre_reset_busy", 32'(tx_status), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_txd", 32'(uart_txd), 32'd1);
        check("midrst_tx_status", 32'(tx_status), 32'd1);
        check("midrst_rx_data", 32'(rx_data), 32'h00);
        check("midrst_rx_status", 32'(rx_status), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
